// File: rtl/mesi_isc_bcast_monitor_if.sv
// Broadcast-path signal bundle observed by mesi_isc_bcast_monitor.
// The master side drives the mbus/cbus activity; the monitor only listens.
interface mesi_isc_bcast_monitor_if #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [3*CORES-1:0]          mbus_cmd_i;
  logic [ADDR_WIDTH*CORES-1:0] mbus_addr_i;
  logic [CORES-1:0]            cbus_ack_i;
  logic [ADDR_WIDTH-1:0]       cbus_addr_o;
  logic [3*CORES-1:0]          cbus_cmd_o;

  modport master (
    output mbus_cmd_i, mbus_addr_i, cbus_ack_i, cbus_addr_o, cbus_cmd_o
  );
  modport slave (
    input  mbus_cmd_i, mbus_addr_i, cbus_ack_i, cbus_addr_o, cbus_cmd_o
  );
endinterface

// File: rtl/mesi_isc_bcast_monitor.sv
// Protocol monitor for the mesi_isc broadcast path: capture -> snoops/acks -> enable.
// Define MESI_ISC_BCAST_MON_LAT_EN to add max_lat_o (worst capture-to-enable latency).

module mesi_isc_bcast_monitor_lane (
  input  logic [2:0] cmd,
  input  logic       ack,
  input  logic       is_req,
  input  logic       wr,
  input  logic       seen_q,
  input  logic       addr_ok,
  output logic       seen_d,
  output logic       acked,
  output logic       addr_err,
  output logic       own_err,
  output logic       type_err
);
  logic exp_snp, opp_snp;

  assign exp_snp  = !is_req && (cmd == (wr ? 3'd1 : 3'd2));
  assign opp_snp  = !is_req && (cmd == (wr ? 3'd2 : 3'd1));
  // an ack only counts once its snoop has been seen, possibly in the same cycle
  assign seen_d   = seen_q | exp_snp;
  assign acked    = !is_req && ack && seen_d;
  assign addr_err = exp_snp && !addr_ok;
  assign own_err  = is_req && (cmd != 3'd0);
  assign type_err = opp_snp;
endmodule

module mesi_isc_bcast_monitor #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  mesi_isc_bcast_monitor_if.slave    bus,
  output logic                       busy_o,
  output logic [$clog2(CORES)-1:0]   req_id_o,
  output logic                       err_o,
  output logic [2:0]                 err_code_o,
  output logic [CNT_WIDTH-1:0]       txn_cnt_o
`ifdef MESI_ISC_BCAST_MON_LAT_EN
  ,output logic [$clog2(2*TIMEOUT+1)-1:0] max_lat_o
`endif
);
  localparam int            IW = $clog2(CORES);
  localparam int            TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SNOOP  = 2'd1;
  localparam logic [1:0] ENABLE = 2'd2;

  localparam logic [2:0] BC_WR = 3'd3;
  localparam logic [2:0] BC_RD = 3'd4;
  localparam logic [2:0] EN_WR = 3'd3;
  localparam logic [2:0] EN_RD = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [CORES-1:0]      snoop_seen_q, snoop_seen_d;
  logic [CORES-1:0]      ack_seen_q, ack_seen_d;
  logic                  err_q, err_d;
  logic [2:0]            code_q, code_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [CORES-1:0] req_oh, lane_seen, lane_ack, lane_addr_err, lane_own_err, lane_type_err;
  logic             addr_ok;
  logic [2:0]       req_cmd;
  logic [5:1]       err_vec;
  logic             done;

  assign addr_ok = (bus.cbus_addr_o == addr_q);
  assign req_oh  = CORES'(1) << req_q;

  for (genvar k = 0; k < CORES; k++) begin : g_lane
    mesi_isc_bcast_monitor_lane u_lane (
      .cmd      (bus.cbus_cmd_o[3*k +: 3]),
      .ack      (bus.cbus_ack_i[k]),
      .is_req   (req_oh[k]),
      .wr       (wr_q),
      .seen_q   (snoop_seen_q[k]),
      .addr_ok  (addr_ok),
      .seen_d   (lane_seen[k]),
      .acked    (lane_ack[k]),
      .addr_err (lane_addr_err[k]),
      .own_err  (lane_own_err[k]),
      .type_err (lane_type_err[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    snoop_seen_d = snoop_seen_q;
    ack_seen_d   = ack_seen_q;
    err_d        = err_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    err_vec      = '0;
    done         = 1'b0;
    req_cmd      = '0;
    for (int k = 0; k < CORES; k++)
      if (req_q == IW'(k)) req_cmd = bus.cbus_cmd_o[3*k +: 3];

    case (state_q)
      IDLE: begin
        // descending scan so the lowest-index broadcaster wins
        for (int k = CORES-1; k >= 0; k--) begin
          if (bus.mbus_cmd_i[3*k +: 3] inside {BC_WR, BC_RD}) begin
            req_d        = IW'(k);
            addr_d       = bus.mbus_addr_i[ADDR_WIDTH*k +: ADDR_WIDTH];
            wr_d         = (bus.mbus_cmd_i[3*k +: 3] == BC_WR);
            snoop_seen_d = '0;
            ack_seen_d   = '0;
            timer_d      = '0;
            state_d      = SNOOP;
          end
        end
      end
      SNOOP: begin
        timer_d      = timer_q + 1'b1;
        snoop_seen_d = lane_seen;
        ack_seen_d   = ack_seen_q | lane_ack;
        err_vec[1]   = (timer_q == TO);
        err_vec[3]   = |lane_addr_err;
        err_vec[4]   = |lane_own_err;
        err_vec[5]   = |lane_type_err;
        if (&(ack_seen_d | req_oh)) begin
          timer_d = '0;
          state_d = ENABLE;
        end
      end
      ENABLE: begin
        timer_d    = timer_q + 1'b1;
        err_vec[2] = (timer_q == TO);
        if (req_cmd == (wr_q ? EN_WR : EN_RD)) begin
          err_vec[3] = !addr_ok;
          done       = addr_ok;
        end
        err_vec[5] = (req_cmd == (wr_q ? EN_RD : EN_WR));
      end
      default: state_d = IDLE;
    endcase

    // errors pre-empt completion; only the first error's code is kept
    if (|err_vec) begin
      state_d = IDLE;
      err_d   = 1'b1;
      if (!err_q)
        for (int c = 5; c >= 1; c--)
          if (err_vec[c]) code_d = 3'(c);
    end else if (done) begin
      state_d = IDLE;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      req_q        <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      snoop_seen_q <= '0;
      ack_seen_q   <= '0;
      err_q        <= 1'b0;
      code_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      snoop_seen_q <= snoop_seen_d;
      ack_seen_q   <= ack_seen_d;
      err_q        <= err_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign req_id_o   = req_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign txn_cnt_o  = cnt_q;

`ifdef MESI_ISC_BCAST_MON_LAT_EN
  localparam int LW = $clog2(2*TIMEOUT+1);
  logic [LW-1:0] lat_q, lat_d, max_q, max_d;

  // lat_d is the 1-based cycle count since capture, i.e. the latency if this cycle completes
  always_comb begin
    lat_d = (state_q == IDLE) ? '0 : lat_q + 1'b1;
    max_d = max_q;
    if (done && !(|err_vec) && (lat_d > max_q)) max_d = lat_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
      max_q <= '0;
    end else begin
      lat_q <= lat_d;
      max_q <= max_d;
    end
  end

  assign max_lat_o = max_q;
`endif
endmodule

// File: tb/tb_mesi_isc_bcast_monitor.sv
// Bench for mesi_isc_bcast_monitor: directed and random broadcasts scored by a
// transaction-level model (phase deadlines computed from the schedule).
module tb_mesi_isc_bcast_monitor;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TO = 10;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mesi_isc_bcast_monitor_if #(.CORES(N), .ADDR_WIDTH(AW)) bus();

  logic          busy;
  logic [1:0]    req_id;
  logic          err;
  logic [2:0]    code;
  logic [CW-1:0] cnt;
`ifdef MESI_ISC_BCAST_MON_LAT_EN
  logic [4:0]    max_lat;
`endif

  mesi_isc_bcast_monitor #(.CORES(N), .ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy),
    .req_id_o   (req_id),
    .err_o      (err),
    .err_code_o (code),
    .txn_cnt_o  (cnt)
`ifdef MESI_ISC_BCAST_MON_LAT_EN
    ,.max_lat_o (max_lat)
`endif
  );

  int total = 0;
  int bad   = 0;

  // model state
  bit m_err;
  int m_code, m_cnt, m_max;

  // per-transaction schedule
  int          s_cyc[N];
  int          a_cyc[N];
  bit          spur[N];
  int          bad_snp_core, inj_cyc, inj_core;
  logic [2:0]  inj_cmd;
  bit          bad_en;
  logic [3*N-1:0] hold_cmd;
  int          ec, ecode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void pick(input int c, input int cd);
    if (c < ec || (c == ec && cd < ecode)) begin
      ec    = c;
      ecode = cd;
    end
  endfunction

  task automatic clr_cfg();
    bad_snp_core = -1;
    inj_cyc      = 0;
    inj_core     = 0;
    inj_cmd      = '0;
    bad_en       = 1'b0;
    for (int j = 0; j < N; j++) spur[j] = 1'b0;
  endtask

  task automatic sched(input int s, input int a);
    for (int j = 0; j < N; j++) begin
      s_cyc[j] = s;
      a_cyc[j] = a;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mbus_cmd_i  = '0;
    bus.cbus_cmd_o  = '0;
    bus.cbus_ack_i  = '0;
    hold_cmd        = '0;
    cyc();
    rst   = 1'b0;
    m_err = 1'b0;
    m_code = 0;
    m_cnt  = 0;
    m_max  = 0;
  endtask

  task automatic check_outs(input int r);
    chk("busy_idle", busy, 0);
    chk("err", err, m_err);
    chk("err_code", code, m_code);
    chk("txn_cnt", cnt, m_cnt);
    chk("req_id", req_id, r);
`ifdef MESI_ISC_BCAST_MON_LAT_EN
    chk("max_lat", max_lat, m_max);
`endif
  endtask

  // One broadcast from requester r; e is the enable cycle counted within the enable phase.
  task automatic run_txn(input int r, input bit wr, input logic [AW-1:0] addr, input int e);
    int ma, en_c, n;
    logic [3*N-1:0] cmd;
    logic [N-1:0]   ack;
    logic [AW-1:0]  caddr;
    bit any_snp, badnow;
    ma = 0;
    for (int j = 0; j < N; j++)
      if (j != r && a_cyc[j] > ma) ma = a_cyc[j];
    ec = 1 << 30;
    ecode = 0;
    en_c = 0;
    if (ma > TO) pick(TO + 1, 1);
    if (bad_snp_core >= 0) pick(s_cyc[bad_snp_core], 3);
    if (inj_cyc > 0) pick(inj_cyc, (inj_core == r) ? 4 : 5);
    if (ma <= TO) begin
      if (e > TO) pick(ma + TO + 1, 2);
      else begin
        en_c = ma + e;
        if (bad_en) pick(en_c, 3);
      end
    end
    n = (ecode != 0) ? ec : en_c;

    bus.mbus_cmd_i = hold_cmd;
    bus.mbus_cmd_i[3*r +: 3] = wr ? 3'd3 : 3'd4;
    for (int j = 0; j < N; j++)
      bus.mbus_addr_i[AW*j +: AW] = (j == r) ? addr : AW'($urandom);
    cyc();
    bus.mbus_cmd_i = hold_cmd;

    for (int c = 1; c <= n; c++) begin
      if (c == n) begin
        chk("busy_mid", busy, 1);
        chk("err_pre", err, m_err);
        chk("req_mid", req_id, r);
      end
      cmd = '0;
      ack = '0;
      caddr = AW'($urandom);
      any_snp = 1'b0;
      badnow = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j != r) begin
          if (c == s_cyc[j]) begin
            cmd[3*j +: 3] = wr ? 3'd1 : 3'd2;
            any_snp = 1'b1;
            if (j == bad_snp_core) badnow = 1'b1;
          end
          if (c == a_cyc[j] || (spur[j] && c == s_cyc[j] - 1)) ack[j] = 1'b1;
        end
      end
      if (any_snp) caddr = badnow ? (addr ^ 32'h4) : addr;
      if (c == en_c) begin
        cmd[3*r +: 3] = wr ? 3'd3 : 3'd4;
        caddr = bad_en ? (addr ^ 32'h8) : addr;
      end
      if (c == inj_cyc) cmd[3*inj_core +: 3] = inj_cmd;
      bus.cbus_cmd_o  = cmd;
      bus.cbus_ack_i  = ack;
      bus.cbus_addr_o = caddr;
      cyc();
    end
    bus.cbus_cmd_o = '0;
    bus.cbus_ack_i = '0;

    if (ecode != 0) begin
      if (!m_err) m_code = ecode;
      m_err = 1'b1;
    end else begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (en_c > m_max) m_max = en_c;
    end
    check_outs(r);
  endtask

  initial begin
    bus.mbus_cmd_i  = '0;
    bus.mbus_addr_i = '0;
    bus.cbus_ack_i  = '0;
    bus.cbus_addr_o = '0;
    bus.cbus_cmd_o  = '0;
    clr_cfg();
    do_reset();
    check_outs(0);

    // basic write broadcast: snoops at 2, acks at 3, enable at absolute cycle 5
    sched(2, 3);
    run_txn(0, 1'b1, 32'h100, 2);
    // read broadcast, latency 4 + 4 = 8
    sched(1, 4);
    run_txn(1, 1'b0, 32'h2000, 4);
    // core3 never snooped -> snoop timeout
    sched(2, 3);
    s_cyc[3] = 99;
    a_cyc[3] = 99;
    run_txn(2, 1'b0, 32'h300, 1);

    // enable on the last legal cycle, then one cycle late
    do_reset();
    sched(1, 3);
    run_txn(2, 1'b0, 32'h440, 10);
    run_txn(2, 1'b0, 32'h480, 11);

    // bad snoop address, then a timeout must not overwrite the first code
    do_reset();
    sched(2, 3);
    bad_snp_core = 0;
    run_txn(1, 1'b1, 32'hA0, 1);
    clr_cfg();
    sched(2, 3);
    a_cyc[2] = 50;
    run_txn(1, 1'b1, 32'hA0, 1);

    // command on requester's own channel
    do_reset();
    sched(2, 3);
    inj_cyc = 2; inj_core = 0; inj_cmd = 3'd3;
    run_txn(0, 1'b1, 32'h500, 1);
    // opposite snoop type
    do_reset();
    clr_cfg();
    sched(2, 3);
    inj_cyc = 1; inj_core = 2; inj_cmd = 3'd2;
    run_txn(0, 1'b1, 32'h600, 1);
    // same-cycle addr error (3) and type error (5): lower code wins
    do_reset();
    clr_cfg();
    sched(2, 3);
    bad_snp_core = 1;
    inj_cyc = 2; inj_core = 2; inj_cmd = 3'd2;
    run_txn(0, 1'b1, 32'h700, 1);

    // cores 1 and 3 broadcast together: 1 first, 3 picked up afterwards
    do_reset();
    clr_cfg();
    sched(1, 2);
    hold_cmd = '0;
    hold_cmd[9 +: 3] = 3'd4;
    run_txn(1, 1'b1, 32'h800, 1);
    hold_cmd = '0;
    run_txn(3, 1'b0, 32'h900, 2);
    // force an error, then reset in the middle of a snoop phase
    s_cyc[0] = 99; a_cyc[0] = 99;
    run_txn(3, 1'b0, 32'h910, 1);
    bus.mbus_cmd_i[3*2 +: 3] = 3'd3;
    cyc();
    bus.mbus_cmd_i = '0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_code", code, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_req", req_id, 0);
    rst = 1'b0;
    m_err = 1'b0; m_code = 0; m_cnt = 0; m_max = 0;
    sched(1, 1);
    run_txn(2, 1'b1, 32'hC0, 1);

    // random traffic; counter saturates at 7
    for (int it = 0; it < 60; it++) begin
      if (it == 30) do_reset();
      clr_cfg();
      for (int j = 0; j < N; j++) begin
        s_cyc[j] = 1 + int'($urandom_range(0, 3));
        a_cyc[j] = s_cyc[j] + int'($urandom_range(0, 8));
        spur[j]  = 1'($urandom_range(0, 1));
      end
      bad_en = ($urandom_range(0, 7) == 0);
      run_txn(int'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)), AW'($urandom),
              1 + int'($urandom_range(0, 11)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
